// File: rtl/tl_tx_credit_gate.sv
// Transaction-layer TX stage: gates whole TLPs on partner credit limits and
// free retry space, then serializes header and payload beats toward the DLL.
`timescale 1ns/1ps
module tl_tx_credit_gate #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int CREDIT_DEPTH    = 12,
  parameter int LEN_WIDTH       = 4
) (
  input  logic                         sclk,
  input  logic                         srst_n,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [1:0]                   req_type_i,
  input  logic [LEN_WIDTH-1:0]         req_len_i,
  input  logic [PIPE_DATA_WIDTH-1:0]   req_hdr_i,
  input  logic                         pld_valid_i,
  output logic                         pld_ready_o,
  input  logic [PIPE_DATA_WIDTH-1:0]   pld_data_i,
  input  logic [CREDIT_DEPTH-1:0]      ep_cl_p_h_i,
  input  logic [CREDIT_DEPTH-1:0]      ep_cl_p_d_i,
  input  logic [CREDIT_DEPTH-1:0]      ep_cl_np_h_i,
  input  logic [CREDIT_DEPTH-1:0]      ep_cl_cpl_h_i,
  input  logic [CREDIT_DEPTH-1:0]      ep_cl_cpl_d_i,
  input  logic                         ep_cl_en_i,
  input  logic [RETRY_DEPTH_LG2+2:0]   retry_buffer_leftover_cnt_i,
  output logic [PIPE_DATA_WIDTH-1:0]   tl2dll_data_o,
  output logic [2:0]                   tl2dll_en_o,
  output logic [CREDIT_DEPTH-1:0]      cc_p_h_o,
  output logic [CREDIT_DEPTH-1:0]      cc_p_d_o,
  output logic [CREDIT_DEPTH-1:0]      cc_np_h_o,
  output logic [CREDIT_DEPTH-1:0]      cc_cpl_h_o,
  output logic [CREDIT_DEPTH-1:0]      cc_cpl_d_o
);

  localparam int RW = RETRY_DEPTH_LG2 + 3;
  localparam logic [CREDIT_DEPTH-1:0] CR_ONE = CREDIT_DEPTH'(1);

  // state  | meaning (state names what tl2dll_* currently shows)
  // IDLE   | nothing on the bus, may accept a TLP
  // HDR    | header beat on the bus; payload already fetched this cycle
  // DATA   | payload beat or stall bubble on the bus
  // DONE   | end-of-TLP code on the bus
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t                      state, state_nx;
  logic [CREDIT_DEPTH-1:0]     cl_p_h, cl_p_d, cl_np_h, cl_cpl_h, cl_cpl_d;
  logic                        cl_valid;
  logic [1:0]                  type_q;
  logic [LEN_WIDTH-1:0]        rem_q, rem_nx;
  logic [2:0]                  en_nx;
  logic [PIPE_DATA_WIDTH-1:0]  data_nx;

  logic [CREDIT_DEPTH-1:0]     sel_cl_h, sel_cc_h, sel_cl_d, sel_cc_d;
  logic [CREDIT_DEPTH-1:0]     need_d, h_room, d_room;
  logic                        has_data, credit_ok, retry_ok, accept;
  logic [LEN_WIDTH-1:0]        len_eff;
  logic [RW-1:0]               retry_need;

  function automatic logic [2:0] hdr_code(input logic [1:0] t);
    case (t)
      2'd1:    return 3'b011;
      2'd2:    return 3'b101;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] data_code(input logic [1:0] t);
    return (t == 2'd2) ? 3'b110 : 3'b010;
  endfunction

  always_comb begin
    sel_cl_h = cl_p_h;
    sel_cc_h = cc_p_h_o;
    sel_cl_d = cl_p_d;
    sel_cc_d = cc_p_d_o;
    has_data = 1'b1;
    case (req_type_i)
      2'd1: begin
        sel_cl_h = cl_np_h;
        sel_cc_h = cc_np_h_o;
        has_data = 1'b0;
      end
      2'd2: begin
        sel_cl_h = cl_cpl_h;
        sel_cc_h = cc_cpl_h_o;
        sel_cl_d = cl_cpl_d;
        sel_cc_d = cc_cpl_d_o;
      end
      default: ;
    endcase
  end

  assign len_eff    = has_data ? req_len_i : '0;
  assign need_d     = CREDIT_DEPTH'({len_eff, 1'b0});
  // Half-range modular compare keeps the check valid across counter wrap.
  assign h_room     = sel_cl_h - (sel_cc_h + CR_ONE);
  assign d_room     = sel_cl_d - (sel_cc_d + need_d);
  assign credit_ok  = !h_room[CREDIT_DEPTH-1] && (!has_data || !d_room[CREDIT_DEPTH-1]);
  assign retry_need = RW'({len_eff, 3'b000}) + RW'(8);
  assign retry_ok   = retry_buffer_leftover_cnt_i >= retry_need;

  assign req_ready_o = (state == S_IDLE) && cl_valid && credit_ok && retry_ok &&
                       (req_type_i != 2'd3);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_nx    = state;
    rem_nx      = rem_q;
    en_nx       = 3'b000;
    data_nx     = '0;
    pld_ready_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_HDR;
          en_nx    = hdr_code(req_type_i);
          data_nx  = req_hdr_i;
          rem_nx   = len_eff;
        end
      end
      S_HDR, S_DATA: begin
        if (rem_q == '0) begin
          state_nx = S_DONE;
          en_nx    = 3'b111;
        end else begin
          state_nx    = S_DATA;
          pld_ready_o = 1'b1;
          if (pld_valid_i) begin
            en_nx   = data_code(type_q);
            data_nx = pld_data_i;
            rem_nx  = rem_q - LEN_WIDTH'(1);
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state         <= S_IDLE;
      rem_q         <= '0;
      type_q        <= '0;
      tl2dll_en_o   <= '0;
      tl2dll_data_o <= '0;
      cl_p_h        <= '0;
      cl_p_d        <= '0;
      cl_np_h       <= '0;
      cl_cpl_h      <= '0;
      cl_cpl_d      <= '0;
      cl_valid      <= 1'b0;
      cc_p_h_o      <= '0;
      cc_p_d_o      <= '0;
      cc_np_h_o     <= '0;
      cc_cpl_h_o    <= '0;
      cc_cpl_d_o    <= '0;
    end else begin
      state         <= state_nx;
      rem_q         <= rem_nx;
      tl2dll_en_o   <= en_nx;
      tl2dll_data_o <= data_nx;
      if (accept) type_q <= req_type_i;
      if (ep_cl_en_i) begin
        cl_p_h   <= ep_cl_p_h_i;
        cl_p_d   <= ep_cl_p_d_i;
        cl_np_h  <= ep_cl_np_h_i;
        cl_cpl_h <= ep_cl_cpl_h_i;
        cl_cpl_d <= ep_cl_cpl_d_i;
        cl_valid <= 1'b1;
      end
      if (accept) begin
        case (req_type_i)
          2'd0: begin
            cc_p_h_o <= cc_p_h_o + CR_ONE;
            cc_p_d_o <= cc_p_d_o + need_d;
          end
          2'd1: cc_np_h_o <= cc_np_h_o + CR_ONE;
          2'd2: begin
            cc_cpl_h_o <= cc_cpl_h_o + CR_ONE;
            cc_cpl_d_o <= cc_cpl_d_o + need_d;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tl_tx_credit_gate.sv
// Scoreboard bench for tl_tx_credit_gate: stimulus pushes expected beats,
// a negedge monitor pops and compares every beat of each TLP frame.
`timescale 1ns/1ps
module tb_tl_tx_credit_gate;
  localparam int DW = 256;
  localparam int CD = 12;
  localparam int LW = 4;
  localparam int RW = 11;

  logic           sclk = 1'b0;
  logic           srst_n = 1'b0;
  logic           req_valid_i = 1'b0;
  logic           req_ready_o;
  logic [1:0]     req_type_i = '0;
  logic [LW-1:0]  req_len_i = '0;
  logic [DW-1:0]  req_hdr_i = '0;
  logic           pld_valid_i = 1'b0;
  logic           pld_ready_o;
  logic [DW-1:0]  pld_data_i = '0;
  logic [CD-1:0]  ep_cl_p_h_i = '0, ep_cl_p_d_i = '0, ep_cl_np_h_i = '0;
  logic [CD-1:0]  ep_cl_cpl_h_i = '0, ep_cl_cpl_d_i = '0;
  logic           ep_cl_en_i = 1'b0;
  logic [RW-1:0]  retry_buffer_leftover_cnt_i = 11'd2047;
  logic [DW-1:0]  tl2dll_data_o;
  logic [2:0]     tl2dll_en_o;
  logic [CD-1:0]  cc_p_h_o, cc_p_d_o, cc_np_h_o, cc_cpl_h_o, cc_cpl_d_o;

  always #5 sclk = ~sclk;

  tl_tx_credit_gate dut (
    .sclk(sclk), .srst_n(srst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_type_i(req_type_i), .req_len_i(req_len_i), .req_hdr_i(req_hdr_i),
    .pld_valid_i(pld_valid_i), .pld_ready_o(pld_ready_o), .pld_data_i(pld_data_i),
    .ep_cl_p_h_i(ep_cl_p_h_i), .ep_cl_p_d_i(ep_cl_p_d_i), .ep_cl_np_h_i(ep_cl_np_h_i),
    .ep_cl_cpl_h_i(ep_cl_cpl_h_i), .ep_cl_cpl_d_i(ep_cl_cpl_d_i), .ep_cl_en_i(ep_cl_en_i),
    .retry_buffer_leftover_cnt_i(retry_buffer_leftover_cnt_i),
    .tl2dll_data_o(tl2dll_data_o), .tl2dll_en_o(tl2dll_en_o),
    .cc_p_h_o(cc_p_h_o), .cc_p_d_o(cc_p_d_o), .cc_np_h_o(cc_np_h_o),
    .cc_cpl_h_o(cc_cpl_h_o), .cc_cpl_d_o(cc_cpl_d_o)
  );

  typedef struct packed {
    logic [2:0]    en;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            tests = 0;
  int            fails = 0;
  logic          in_frame = 1'b0;
  logic [CD-1:0] m_p_h = '0, m_p_d = '0, m_np_h = '0, m_cpl_h = '0, m_cpl_d = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Once a frame starts, every cycle up to and including DONE is a scoreboard entry.
  always @(negedge sclk) begin
    if (!srst_n) begin
      in_frame = 1'b0;
    end else if (in_frame || tl2dll_en_o != 3'b000) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected: got en %b with nothing expected", tl2dll_en_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (tl2dll_en_o !== mon_e.en || tl2dll_data_o !== mon_e.data) begin
          fails++;
          $display("FAIL mon_beat: got en %b data %h expected en %b data %h",
                   tl2dll_en_o, tl2dll_data_o, mon_e.en, mon_e.data);
        end
      end
      in_frame = (tl2dll_en_o != 3'b111);
    end
  end

  function automatic logic [DW-1:0] mk_hdr(input int id);
    return {8{32'hA000_0000 + 32'(id)}};
  endfunction

  function automatic logic [DW-1:0] beat_v(input logic [DW-1:0] h, input int b);
    return h ^ {8{32'hBEEF_0000 + 32'(b)}};
  endfunction

  function automatic logic [2:0] hc(input logic [1:0] t);
    return (t == 2'd0) ? 3'b001 : (t == 2'd1) ? 3'b011 : 3'b101;
  endfunction

  function automatic logic [2:0] dc(input logic [1:0] t);
    return (t == 2'd0) ? 3'b010 : 3'b110;
  endfunction

  task automatic load_limits(input logic [CD-1:0] ph, pd, nph, ch, cdd);
    @(posedge sclk); #1;
    ep_cl_p_h_i = ph; ep_cl_p_d_i = pd; ep_cl_np_h_i = nph;
    ep_cl_cpl_h_i = ch; ep_cl_cpl_d_i = cdd; ep_cl_en_i = 1'b1;
    @(posedge sclk); #1;
    ep_cl_en_i = 1'b0;
  endtask

  task automatic probe(input string nm, input logic [1:0] t, input logic [LW-1:0] len,
                       input logic v, input logic exp);
    @(posedge sclk); #1;
    req_valid_i = v; req_type_i = t; req_len_i = len;
    @(negedge sclk);
    chk(nm, 64'(req_ready_o), 64'(exp));
  endtask

  // Starts right after a posedge; returns one cycle after the acceptance edge
  // once all payload beats have been offered. stall[k] drops pld_valid_i in
  // the k-th cycle after acceptance.
  task automatic send_tlp(input logic [1:0] t, input logic [LW-1:0] len, input int id,
                          input logic [7:0] stall, output int waited);
    logic [DW-1:0] h;
    logic [LW-1:0] l;
    logic          ok;
    exp_t          e;
    int            k, b;
    h = mk_hdr(id);
    l = (t == 2'd1) ? '0 : len;
    req_valid_i = 1'b1; req_type_i = t; req_len_i = len; req_hdr_i = h;
    waited = 0; ok = 1'b0;
    while (!ok && waited <= 40) begin
      @(negedge sclk);
      if (req_ready_o) ok = 1'b1;
      else begin
        @(posedge sclk); #1;
        waited++;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no req_ready_o for TLP %0d expected acceptance", id);
      req_valid_i = 1'b0;
      waited = -1;
      return;
    end
    e.en = hc(t); e.data = h; exp_q.push_back(e);
    k = 0; b = 0;
    while (b < int'(l)) begin
      if (k < 8 && stall[k]) begin
        e.en = 3'b000; e.data = '0;
      end else begin
        e.en = dc(t); e.data = beat_v(h, b); b++;
      end
      exp_q.push_back(e);
      k++;
    end
    e.en = 3'b111; e.data = '0; exp_q.push_back(e);
    case (t)
      2'd0: begin m_p_h = m_p_h + 12'd1; m_p_d = m_p_d + CD'({l, 1'b0}); end
      2'd1: m_np_h = m_np_h + 12'd1;
      default: begin m_cpl_h = m_cpl_h + 12'd1; m_cpl_d = m_cpl_d + CD'({l, 1'b0}); end
    endcase
    @(posedge sclk); #1;
    req_valid_i = 1'b0;
    chk("cc_p_h", 64'(cc_p_h_o), 64'(m_p_h));
    chk("cc_p_d", 64'(cc_p_d_o), 64'(m_p_d));
    chk("cc_np_h", 64'(cc_np_h_o), 64'(m_np_h));
    chk("cc_cpl_h", 64'(cc_cpl_h_o), 64'(m_cpl_h));
    chk("cc_cpl_d", 64'(cc_cpl_d_o), 64'(m_cpl_d));
    k = 0; b = 0;
    while (b < int'(l)) begin
      pld_valid_i = !(k < 8 && stall[k]);
      pld_data_i  = beat_v(h, b);
      @(posedge sclk); #1;
      if (pld_valid_i) b++;
      k++;
    end
    pld_valid_i = 1'b0;
    pld_data_i  = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [DW-1:0] h;
    int bad;

    #3;
    chk("rst_en", 64'(tl2dll_en_o), 64'd0);
    chk("rst_data_nonzero", 64'(tl2dll_data_o != '0), 64'd0);
    chk("rst_cc_p_h", 64'(cc_p_h_o), 64'd0);
    chk("rst_cc_cpl_d", 64'(cc_cpl_d_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_pld_ready", 64'(pld_ready_o), 64'd0);
    repeat (2) @(posedge sclk);
    #1 srst_n = 1'b1;

    // No limits loaded: nothing may be accepted.
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      probe("nolim_ready", 2'd0, 4'd2, 1'b1, 1'b0);
      if (tl2dll_en_o != 3'b000) bad++;
    end
    chk("nolim_en_idle", 64'(bad), 64'd0);
    @(posedge sclk); #1 req_valid_i = 1'b0;

    // Posted write, len 2, continuous payload.
    load_limits(12'd4, 12'd8, 12'd0, 12'd0, 12'd0);
    send_tlp(2'd0, 4'd2, 1, 8'h00, w);
    chk("pw_wait", 64'(w), 64'd0);
    chk("pw_cc_p_h", 64'(cc_p_h_o), 64'd1);
    chk("pw_cc_p_d", 64'(cc_p_d_o), 64'd4);

    // Data credit block: CC_D=4, CL_D=6, need 4 -> blocked; CL_D=8 -> passes.
    load_limits(12'd4, 12'd6, 12'd0, 12'd0, 12'd0);
    probe("blk_ready0", 2'd0, 4'd2, 1'b1, 1'b0);
    probe("blk_ready1", 2'd0, 4'd2, 1'b1, 1'b0);
    @(posedge sclk); #1;
    ep_cl_p_d_i = 12'd8; ep_cl_en_i = 1'b1;
    @(negedge sclk);
    chk("blk_old_limit_cycle", 64'(req_ready_o), 64'd0);
    @(posedge sclk); #1 ep_cl_en_i = 1'b0;
    send_tlp(2'd0, 4'd2, 2, 8'h00, w);
    chk("blk_wait", 64'(w), 64'd0);
    chk("blk_cc_p_d", 64'(cc_p_d_o), 64'd8);

    // Retry gate and NP (len input ignored for NP).
    load_limits(12'd4, 12'd8, 12'd1, 12'd0, 12'd0);
    retry_buffer_leftover_cnt_i = 11'd7;
    probe("np_retry7", 2'd1, 4'd5, 1'b1, 1'b0);
    probe("np_retry7b", 2'd1, 4'd5, 1'b1, 1'b0);
    @(posedge sclk); #1 retry_buffer_leftover_cnt_i = 11'd8;
    send_tlp(2'd1, 4'd5, 3, 8'h00, w);
    chk("np_wait", 64'(w), 64'd0);
    chk("np_cc_np_h", 64'(cc_np_h_o), 64'd1);
    retry_buffer_leftover_cnt_i = 11'd2047;
    repeat (3) @(posedge sclk);
    #1;
    load_limits(12'd100, 12'd100, 12'd100, 12'd100, 12'd100);
    probe("illegal_type", 2'd3, 4'd0, 1'b1, 1'b0);
    probe("legal_np_open", 2'd1, 4'd0, 1'b0, 1'b1);
    probe("p_retry_len15_low", 2'd0, 4'd15, 1'b0, 1'b1);

    // CPL len 3 with a two-cycle payload stall.
    load_limits(12'd4, 12'd8, 12'd5, 12'd1, 12'd6);
    send_tlp(2'd2, 4'd3, 4, 8'b0000_0110, w);
    chk("cpl_wait", 64'(w), 64'd0);
    chk("cpl_cc_cpl_d", 64'(cc_cpl_d_o), 64'd6);
    repeat (4) @(posedge sclk);
    #1;

    // Reset during DATA.
    load_limits(12'd4, 12'd8, 12'd5, 12'd2, 12'd12);
    h = mk_hdr(900);
    @(posedge sclk); #1;
    req_valid_i = 1'b1; req_type_i = 2'd2; req_len_i = 4'd3; req_hdr_i = h;
    @(negedge sclk);
    chk("rst_pre_ready", 64'(req_ready_o), 64'd1);
    mon_e.en = 3'b101; mon_e.data = h; exp_q.push_back(mon_e);
    @(posedge sclk); #1;
    req_valid_i = 1'b0; pld_valid_i = 1'b1; pld_data_i = beat_v(h, 0);
    @(posedge sclk); #1;
    pld_valid_i = 1'b0;
    chk("mid_pld_ready", 64'(pld_ready_o), 64'd1);
    srst_n = 1'b0;
    #1;
    chk("mid_rst_en", 64'(tl2dll_en_o), 64'd0);
    chk("mid_rst_data_nonzero", 64'(tl2dll_data_o != '0), 64'd0);
    chk("mid_rst_cc_cpl_h", 64'(cc_cpl_h_o), 64'd0);
    chk("mid_rst_cc_p_d", 64'(cc_p_d_o), 64'd0);
    chk("mid_rst_pld_ready", 64'(pld_ready_o), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready_o), 64'd0);
    exp_q.delete();
    m_p_h = '0; m_p_d = '0; m_np_h = '0; m_cpl_h = '0; m_cpl_d = '0;
    @(posedge sclk); #1 srst_n = 1'b1;
    probe("post_rst_no_limits", 2'd0, 4'd0, 1'b0, 1'b0);

    // Walk CC_P_H up to 4095, then cross the wrap.
    for (int i = 0; i < 4095; i++) begin
      load_limits(m_p_h + 12'd1, 12'd0, 12'd0, 12'd0, 12'd0);
      send_tlp(2'd0, 4'd0, 1000 + i, 8'h00, w);
    end
    chk("wrap_pre_cc", 64'(cc_p_h_o), 64'd4095);
    load_limits(12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    probe("wrap_ready_at_4095", 2'd0, 4'd0, 1'b0, 1'b1);
    @(posedge sclk); #1;
    send_tlp(2'd0, 4'd0, 7000, 8'h00, w);
    chk("wrap_cc_zero", 64'(cc_p_h_o), 64'd0);
    repeat (3) @(posedge sclk);
    probe("wrap_blocked", 2'd0, 4'd0, 1'b0, 1'b0);
    load_limits(12'd1, 12'd0, 12'd0, 12'd0, 12'd0);
    probe("wrap_advanced", 2'd0, 4'd0, 1'b0, 1'b1);
    @(posedge sclk); #1;
    send_tlp(2'd0, 4'd0, 7001, 8'h00, w);
    chk("wrap_cc_one", 64'(cc_p_h_o), 64'd1);

    repeat (6) @(posedge sclk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
